// File: rtl/tbre_pkg.sv
// Shared types and field positions for the TBRE sweep engine and its register block.
package tbre_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StRevAddr,
        StRevChk,
        StWrReq,
        StNext
    } tbre_state_e;

    // Fields of the corein vector driven by the register block.
    localparam int unsigned TBRE_START_LSB = 0;
    localparam int unsigned TBRE_END_LSB   = 32;
    localparam int unsigned TBRE_GO_BIT    = 64;

    // Fields of the coreout vector returned to the register block.
    localparam int unsigned TBRE_BUSY_BIT  = 0;
    localparam int unsigned TBRE_CNT_LSB   = 32;

    localparam int unsigned CAP_TAG_BIT    = 64;

endpackage

// File: rtl/tbre_sweep_engine.sv
// Background revocation sweep: reads each granule, checks the revocation bit of tagged
// capabilities and writes them back untagged. Optional revoked counter: TBRE_SWEEP_STATS_EN.
module tbre_sweep_engine
    import tbre_pkg::*;
#(
    parameter int unsigned GRANULE_LOG2 = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [127:0]  mmreg_corein_i,
    output logic [63:0]   mmreg_coreout_o,
    output logic          mem_req_o,
    input  logic          mem_gnt_i,
    output logic          mem_we_o,
    output logic [31:0]   mem_addr_o,
    output logic [64:0]   mem_wdata_o,
    input  logic          mem_rvalid_i,
    input  logic [64:0]   mem_rdata_i,
    output logic [31:0]   rev_addr_o,
    input  logic          rev_bit_i
);

    localparam logic [32:0] Step      = 33'(1) << GRANULE_LOG2;
    localparam logic [31:0] AlignMask = ~((32'(1) << GRANULE_LOG2) - 32'd1);

    tbre_state_e state_q, state_d;
    logic [31:0] cur_q, cur_d;
    logic [31:0] end_q, end_d;
    logic [63:0] data_q, data_d;
    logic        cnt_inc, cnt_clr;
    logic [31:0] cnt;
    logic [32:0] next_addr;

    logic        go;
    logic [31:0] start_aligned;
    logic [31:0] end_in;

    assign go            = mmreg_corein_i[TBRE_GO_BIT];
    assign start_aligned = mmreg_corein_i[TBRE_START_LSB +: 32] & AlignMask;
    assign end_in        = mmreg_corein_i[TBRE_END_LSB +: 32];

    logic unused_corein;
    assign unused_corein = ^mmreg_corein_i[127:65];

    // 33-bit sum so a range ending near the top of memory terminates instead of wrapping.
    assign next_addr = {1'b0, cur_q} + Step;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        data_d  = data_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    cur_d   = start_aligned;
                    end_d   = end_in;
                    cnt_clr = 1'b1;
                    state_d = (end_in <= start_aligned) ? StNext : StRdReq;
                end
            end
            StRdReq: begin
                if (mem_gnt_i) state_d = StRdWait;
            end
            StRdWait: begin
                if (mem_rvalid_i) begin
                    data_d  = mem_rdata_i[63:0];
                    state_d = mem_rdata_i[CAP_TAG_BIT] ? StRevAddr : StNext;
                end
            end
            StRevAddr: state_d = StRevChk;
            StRevChk:  state_d = rev_bit_i ? StWrReq : StNext;
            StWrReq: begin
                if (mem_gnt_i) begin
                    cnt_inc = 1'b1;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (next_addr >= {1'b0, end_q}) begin
                    state_d = StIdle;
                end else begin
                    cur_d   = next_addr[31:0];
                    state_d = StRdReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cur_q   <= '0;
            end_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            data_q  <= data_d;
        end
    end

`ifdef TBRE_SWEEP_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = cnt_inc ^ cnt_clr;
    assign cnt        = '0;
`endif

    assign mem_req_o   = (state_q == StRdReq) || (state_q == StWrReq);
    assign mem_we_o    = (state_q == StWrReq);
    assign mem_addr_o  = cur_q;
    assign mem_wdata_o = {1'b0, data_q};
    assign rev_addr_o  = data_q[31:0];

    always_comb begin
        mmreg_coreout_o                       = '0;
        mmreg_coreout_o[TBRE_BUSY_BIT]        = (state_q != StIdle);
        mmreg_coreout_o[TBRE_CNT_LSB +: 32]   = cnt;
    end

endmodule

// File: tb/tb_tbre_sweep_engine.sv
// Randomized bench for tbre_sweep_engine against a range-walking reference model.
module tb_tbre_sweep_engine;
    import tbre_pkg::*;

`ifdef TBRE_SWEEP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic [127:0]  mmreg_corein_i = '0;
    logic [63:0]   mmreg_coreout_o;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [64:0]   mem_wdata_o;
    logic          mem_rvalid_i = 1'b0;
    logic [64:0]   mem_rdata_i = '0;
    logic [31:0]   rev_addr_o;
    logic          rev_bit_i = 1'b0;
    logic          busy;

    assign busy = mmreg_coreout_o[0];

    tbre_sweep_engine #(.GRANULE_LOG2(3)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .mmreg_corein_i  (mmreg_corein_i),
        .mmreg_coreout_o (mmreg_coreout_o),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .rev_addr_o      (rev_addr_o),
        .rev_bit_i       (rev_bit_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [64:0] mem [logic [31:0]];
    bit          rev_set [logic [31:0]];

    // Environment state.
    bit          rd_pend = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [31:0] rev_prev = '0;
    bit          rev_log_next = 1'b0;
    int          stall_left = 0;
    int          busy_cycles = 0;
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [64:0] wr_data_log[$];
    logic [31:0] rev_log[$];
    logic [31:0] stall_addr_log[$];

    // Reference expectations.
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr_addr[$];
    logic [64:0] exp_wr_data[$];
    logic [31:0] exp_rev[$];
    int          exp_busy;
    int          exp_cnt;

    function automatic logic [64:0] mem_rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 65'h0;
    endfunction

    function automatic bit rev_rd(logic [31:0] a);
        if (rev_set.exists(a)) return rev_set[a];
        return 1'b0;
    endfunction

    // Memory, revocation-bitmap responder and logger; inputs change on the falling edge.
    always @(negedge clk) begin
        if (rst_i) begin
            rd_pend      = 1'b0;
            rev_log_next = 1'b0;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            rev_bit_i    = 1'b0;
        end else begin
            if (rev_log_next) rev_log.push_back(rev_addr_o);
            rev_log_next = 1'b0;
            mem_rvalid_i = rd_pend;
            mem_rdata_i  = rd_pend ? mem_rd(rd_addr) : {1'b1, $urandom, $urandom};
            if (rd_pend && mem_rdata_i[64]) rev_log_next = 1'b1;
            rd_pend   = 1'b0;
            rev_bit_i = rev_rd(rev_prev);
            rev_prev  = rev_addr_o;
            mem_gnt_i = 1'b0;
            if (mem_req_o) begin
                if (!mem_we_o && stall_left > 0) begin
                    stall_left--;
                    stall_addr_log.push_back(mem_addr_o);
                end else begin
                    mem_gnt_i = 1'b1;
                    if (mem_we_o) begin
                        wr_addr_log.push_back(mem_addr_o);
                        wr_data_log.push_back(mem_wdata_o);
                        mem[mem_addr_o] = mem_wdata_o;
                    end else begin
                        rd_log.push_back(mem_addr_o);
                        rd_pend = 1'b1;
                        rd_addr = mem_addr_o;
                    end
                end
            end
            if (busy) busy_cycles++;
        end
    end

    // Walk the range as the sweep is described: aligned start, granule steps, stop at end.
    function automatic void build_model(logic [31:0] s, logic [31:0] e, int stall);
        logic [32:0] a;
        logic [64:0] cap;
        exp_rd.delete();
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_rev.delete();
        exp_cnt  = 0;
        a        = {1'b0, s & ~32'h7};
        if ({1'b0, e} <= a) begin
            exp_busy = 1;
        end else begin
            exp_busy = stall;
            while (a < {1'b0, e}) begin
                cap = mem_rd(a[31:0]);
                exp_rd.push_back(a[31:0]);
                if (!cap[64]) begin
                    exp_busy += 3;
                end else begin
                    exp_rev.push_back(cap[31:0]);
                    if (rev_rd(cap[31:0])) begin
                        exp_busy += 6;
                        exp_wr_addr.push_back(a[31:0]);
                        exp_wr_data.push_back({1'b0, cap[63:0]});
                        exp_cnt++;
                    end else begin
                        exp_busy += 5;
                    end
                end
                a += 33'd8;
            end
        end
    endfunction

    task automatic fill(input logic [31:0] base, input int n, input int tag_pct,
                        input logic [31:0] cap_base, input int nbases);
        for (int i = 0; i < n; i++) begin
            logic tag;
            logic [31:0] b;
            tag = ($urandom_range(0, 99) < tag_pct);
            b   = cap_base + 32'($urandom_range(0, nbases - 1)) * 32'd4;
            mem[base + 32'(i) * 32'd8] = {tag, $urandom, b};
        end
    endtask

    task automatic run_sweep(input string name, input logic [31:0] s, input logic [31:0] e,
                             input int stall, input bit go_mid);
        int n;
        build_model(s, e, stall);
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        rev_log.delete();
        stall_addr_log.delete();
        busy_cycles = 0;
        stall_left  = stall;
        @(negedge clk);
        mmreg_corein_i = {31'($urandom), $urandom, 1'b1, e, s};
        @(negedge clk);
        mmreg_corein_i[64] = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_go: got %b expected 1", name, busy);
        end
        checks++;
        if (mem_req_o !== (exp_rd.size() != 0)) begin
            failures++;
            $display("FAIL %s req_after_go: got %b expected %b", name, mem_req_o,
                     exp_rd.size() != 0);
        end
        if (go_mid) begin
            @(negedge clk);
            mmreg_corein_i = {63'h0, 1'b1, 32'h0000_9100, 32'h0000_9000};
            @(negedge clk);
            mmreg_corein_i[64] = 1'b0;
        end
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s timeout: busy got %b expected 0", name, busy);
        end
        checks++;
        if (busy_cycles != exp_busy) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, exp_busy);
        end
        checks++;
        if (rd_log.size() != exp_rd.size()) begin
            failures++;
            $display("FAIL %s read_count: got %0d expected %0d", name, rd_log.size(),
                     exp_rd.size());
        end
        n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (rd_log[i] !== exp_rd[i]) begin
                failures++;
                $display("FAIL %s read_addr[%0d]: got %h expected %h", name, i, rd_log[i],
                         exp_rd[i]);
            end
        end
        checks++;
        if (wr_addr_log.size() != exp_wr_addr.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr_log.size(),
                     exp_wr_addr.size());
        end
        n = (wr_addr_log.size() < exp_wr_addr.size()) ? wr_addr_log.size() : exp_wr_addr.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (wr_addr_log[i] !== exp_wr_addr[i] || wr_data_log[i] !== exp_wr_data[i]) begin
                failures++;
                $display("FAIL %s write[%0d]: got %h/%h expected %h/%h", name, i,
                         wr_addr_log[i], wr_data_log[i], exp_wr_addr[i], exp_wr_data[i]);
            end
        end
        checks++;
        if (rev_log.size() != exp_rev.size()) begin
            failures++;
            $display("FAIL %s rev_count: got %0d expected %0d", name, rev_log.size(),
                     exp_rev.size());
        end
        n = (rev_log.size() < exp_rev.size()) ? rev_log.size() : exp_rev.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (rev_log[i] !== exp_rev[i]) begin
                failures++;
                $display("FAIL %s rev_addr[%0d]: got %h expected %h", name, i, rev_log[i],
                         exp_rev[i]);
            end
        end
        checks++;
        if (mmreg_coreout_o !== {(STATS ? 32'(exp_cnt) : 32'h0), 32'h0}) begin
            failures++;
            $display("FAIL %s coreout: got %h expected %h", name, mmreg_coreout_o,
                     {(STATS ? 32'(exp_cnt) : 32'h0), 32'h0});
        end
    endtask

    task automatic test_reset;
        #1 rst_i = 1'b1;
        #2;
        checks++;
        if (mmreg_coreout_o !== 64'h0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got coreout=%h req=%b we=%b expected 0/0/0",
                     mmreg_coreout_o, mem_req_o, mem_we_o);
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 65'h0 || rev_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h rev=%h expected 0", mem_addr_o,
                     mem_wdata_o, rev_addr_o);
        end
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_untagged;
        fill(32'h1000, 4, 0, 32'h2000, 1);
        run_sweep("untagged", 32'h1000, 32'h1020, 0, 1'b0);
        checks++;
        if (busy_cycles != 12) begin
            failures++;
            $display("FAIL untagged_busy12: got %0d expected 12", busy_cycles);
        end
    endtask

    task automatic test_revoke;
        fill(32'h1000, 4, 0, 32'h2000, 1);
        mem[32'h1008] = {1'b1, 32'hCAFE_F00D, 32'h0000_2000};
        rev_set[32'h2000] = 1'b1;
        run_sweep("revoke", 32'h1000, 32'h1020, 0, 1'b0);
        checks++;
        if (wr_data_log.size() != 1 || wr_data_log[0] !== {1'b0, 32'hCAFE_F00D, 32'h2000}) begin
            failures++;
            $display("FAIL revoke_wdata: got %0d writes expected one untagged write",
                     wr_data_log.size());
        end
    endtask

    task automatic test_empty;
        run_sweep("empty", 32'h1003, 32'h1000, 0, 1'b0);
        run_sweep("empty_eq", 32'h2005, 32'h2000, 0, 1'b0);
    endtask

    task automatic test_stall_ignored_go;
        fill(32'h3000, 4, 50, 32'h3800, 2);
        rev_set[32'h3800] = 1'b1;
        run_sweep("stall", 32'h3000, 32'h3020, 5, 1'b1);
        checks++;
        if (stall_addr_log.size() != 5) begin
            failures++;
            $display("FAIL stall_req_held: got %0d cycles expected 5", stall_addr_log.size());
        end
        foreach (stall_addr_log[i]) begin
            checks++;
            if (stall_addr_log[i] !== 32'h3000) begin
                failures++;
                $display("FAIL stall_addr[%0d]: got %h expected 00003000", i,
                         stall_addr_log[i]);
            end
        end
    endtask

    task automatic test_top_of_memory;
        fill(32'hFFFF_FFF0, 2, 100, 32'h4000, 1);
        rev_set[32'h4000] = 1'b1;
        run_sweep("top_f0", 32'hFFFF_FFF0, 32'hFFFF_FFF8, 0, 1'b0);
        run_sweep("top_ff", 32'hFFFF_FFF8, 32'hFFFF_FFFF, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            logic [31:0] base;
            logic [31:0] s;
            logic [31:0] e;
            base = 32'h5000 + 32'(it) * 32'h100;
            fill(base, 10, 60, 32'h8000, 8);
            for (int b = 0; b < 8; b++) rev_set[32'h8000 + 32'(b) * 32'd4] = 1'($urandom);
            s = base + 32'($urandom_range(0, 15));
            e = base + 32'($urandom_range(0, 72));
            run_sweep("random", s, e, $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_reset_mid_write;
        int writes;
        mem[32'h7000] = {1'b1, $urandom, 32'h0000_7100};
        mem[32'h7008] = {1'b1, $urandom, 32'h0000_7100};
        rev_set[32'h7100] = 1'b1;
        stall_left = 0;
        @(negedge clk);
        mmreg_corein_i = {63'h0, 1'b1, 32'h0000_7010, 32'h0000_7000};
        @(negedge clk);
        mmreg_corein_i[64] = 1'b0;
        writes = 0;
        for (int i = 0; i < 200 && writes < 2; i++) begin
            @(negedge clk);
            if (mem_req_o && mem_we_o) writes++;
        end
        checks++;
        if (writes != 2) begin
            failures++;
            $display("FAIL rst_mid_reach_wr: got %0d writes expected 2", writes);
        end
        checks++;
        if (mmreg_coreout_o !== {(STATS ? 32'd1 : 32'd0), 31'h0, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid_pre: got %h expected %h", mmreg_coreout_o,
                     {(STATS ? 32'd1 : 32'd0), 31'h0, 1'b1});
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || mmreg_coreout_o !== 64'h0) begin
            failures++;
            $display("FAIL rst_mid_async: got req=%b coreout=%h expected 0/0", mem_req_o,
                     mmreg_coreout_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mmreg_coreout_o !== 64'h0 || mem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after: got req=%b coreout=%h expected 0/0", mem_req_o,
                     mmreg_coreout_o);
        end
    endtask

    initial begin
        test_reset();
        test_untagged();
        test_revoke();
        test_empty();
        test_stall_ignored_go();
        test_top_of_memory();
        test_random();
        test_reset_mid_write();
        run_sweep("back_to_back", 32'h1000, 32'h1020, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tbre_sweep_engine.md
# tbre_sweep_engine

Core-side background revocation sweep engine. It consumes the start/end/go vector from the TBRE memory-mapped register block on `mmreg_corein_i` and reports busy status back on `mmreg_coreout_o`. It walks a capability-granule address range over a single-outstanding memory port, looks up the revocation bit for each tagged capability, and writes the capability back with its tag cleared when that bit is set.

## Interface
- `GRANULE_LOG2`, default 3: log2 of the granule size in bytes; the address step is `1 << GRANULE_LOG2`.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `mmreg_corein_i` in 128: [31:0] start, [63:32] end, [64] go pulse, [127:65] ignored.
- `mmreg_coreout_o` out 64: [0] busy, [31:1] zero, [63:32] revoked count.
- `mem_req_o` out 1: memory request.
- `mem_gnt_i` in 1: request accepted.
- `mem_we_o` out 1: 1 = write.
- `mem_addr_o` out 32: granule address.
- `mem_wdata_o` out 65: {tag, data}; tag is always 0 on writes.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in 65: [64] tag, [63:0] capability; [31:0] is the capability base.
- `rev_addr_o` out 32: revocation-bitmap lookup address (the capability base).
- `rev_bit_i` in 1: revocation bit; valid the cycle after `rev_addr_o` is driven.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, REV_ADDR, REV_CHK, WR_REQ, NEXT.
- IDLE + go:
  - latch `cur = start & ~(granule-1)` and `end`; go to RD_REQ.
  - If `end <= cur`, go to NEXT instead; this produces exactly one busy cycle.
- RD_REQ: `mem_req_o=1`, `mem_we_o=0`, `mem_addr_o=cur`, all held stable until `mem_gnt_i`; then go to RD_WAIT.
- RD_WAIT: on `mem_rvalid_i`, capture rdata.
  - tag=0 → NEXT.
  - tag=1 → REV_ADDR.
- REV_ADDR: drive `rev_addr_o` = captured base; go to REV_CHK.
- REV_CHK: sample `rev_bit_i`.
  - 1 → WR_REQ.
  - 0 → NEXT.
- WR_REQ: write {0, captured data} to `cur`, held until `mem_gnt_i`; writes return no `rvalid`. Then increment the revoked count and go to NEXT.
- NEXT: `cur += granule`, computed 33-bit wide.
  - If the sum is `>= {1'b0,end}` → IDLE.
  - Otherwise → RD_REQ. There is no address wrap past 0xFFFFFFFF.
- busy = 1 in every state except IDLE.
- go while busy is ignored; go carries no queueing.
- The revoked count clears to 0 on each accepted go and saturates at 0xFFFFFFFF.
- `mem_rvalid_i` outside RD_WAIT is ignored.
- Reset mid-sweep: FSM → IDLE, `mem_req_o` drops immediately, sweep abandoned, count cleared.

## Timing
- Reset values:
  - `mmreg_coreout_o` = 0.
  - `mem_req_o` = 0, `mem_we_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, `rev_addr_o` = 0.
- All outputs are registered or decoded from FSM and state registers; there is no combinational path from inputs to outputs.
- Go sampled at edge N → busy=1 and first `mem_req_o` visible in cycle N+1.
- Untagged granule with zero-wait memory (gnt in the request cycle, rvalid the next cycle): 3 cycles.
- Revoked granule, zero-wait: 6 cycles.
- busy falls the cycle after NEXT detects the end. The register block sees busy 1→0 and raises done.
- Empty range: busy high for exactly 1 cycle.
- `gnt` and `rvalid` in the same cycle cannot occur, because RD_WAIT is entered only after gnt.

## Configuration
- Macro: `TBRE_SWEEP_STATS_EN`.
- Defined: `mmreg_coreout_o[63:32]` carries the saturating revoked count.
- Undefined: no counter is instantiated and [63:32] is tied to 0; FSM behaviour is identical.

## Structure
- Shared package `tbre_pkg` holds:
  - state enum `tbre_state_e`;
  - corein field positions: `TBRE_START_LSB=0`, `TBRE_END_LSB=32`, `TBRE_GO_BIT=64`;
  - coreout field positions: `TBRE_BUSY_BIT=0`, `TBRE_CNT_LSB=32`;
  - tag bit position `CAP_TAG_BIT=64`.
- No sub-module; the address stepper and FSM live in one module.

## Test plan
- Range 0x1000–0x1020, all tags 0, zero-wait memory → 4 reads at 0x1000/08/10/18, no writes, busy high 12 cycles, count=0.
- Same range, tag=1 at 0x1008 with base 0x2000, `rev_bit_i=1` for 0x2000 → `rev_addr_o`=0x2000, one write to 0x1008 with `mem_wdata_o[64]=0` and data unchanged, count=1.
- start=0x1003, end=0x1000 → no memory request, busy high exactly 1 cycle.
- `mem_gnt_i` withheld 5 cycles on the first read → `mem_addr_o` and `mem_req_o` stable all 5 cycles; second go pulsed mid-sweep is ignored.
- end=0xFFFFFFF8, start=0xFFFFFFF0 → reads at 0xFFFFFFF0 only, no wrap, busy drops.
- `rst_i` asserted during WR_REQ → `mem_req_o`=0 asynchronously, busy=0, count=0 after release.
